// File: rtl/vblank_scheduler_if.sv
// rtl/vblank_scheduler_if.sv - Request/grant and status bundle for the vblank update scheduler
//
// Purpose: groups the line counter input, the per-requester request/done
// handshake, the error-clear strobe and all scheduler status outputs.
// Ports (signals):
//   y[9:0]           current VGA line
//   req[1:0]         update request, bit 0 paddle/ball, bit 1 bricks
//   done[1:0]        requester finished its update (meaningful while granted)
//   clr_err          clears the sticky overrun/timeout flags
//   grant[1:0]       one-hot or zero grant
//   frame_tick       one-cycle pulse at blanking start
//   window_open      grants may be issued
//   frame_count[7:0] blanking intervals seen, modulo 256
//   overrun          sticky: a grant was revoked at window close
//   timeout          sticky: a grant ran for the full cycle budget
// Modports: master drives the inputs of the scheduler, slave is the scheduler.

interface vblank_scheduler_if;
    logic [9:0] y;
    logic [1:0] req;
    logic [1:0] done;
    logic       clr_err;
    logic [1:0] grant;
    logic       frame_tick;
    logic       window_open;
    logic [7:0] frame_count;
    logic       overrun;
    logic       timeout;

    modport master (
        output y, req, done, clr_err,
        input  grant, frame_tick, window_open, frame_count, overrun, timeout
    );

    modport slave (
        input  y, req, done, clr_err,
        output grant, frame_tick, window_open, frame_count, overrun, timeout
    );
endinterface

// File: rtl/vblank_scheduler.sv
// rtl/vblank_scheduler.sv - Grants game-state update slots to two requesters during vertical blanking
//
// Purpose: detects the start of vertical blanking, then arbitrates the
// update window between two requesters, one grant each per frame, until the
// window closes at CLOSE_LINE. Grants are bounded to GRANT_MAX cycles.
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset
//   bus  vblank_scheduler_if.slave (line, req/done, clr_err, grant and status)

module vblank_scheduler #(
    parameter int V_VISIBLE  = 480,
    parameter int CLOSE_LINE = 522,
    parameter int GRANT_MAX  = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    vblank_scheduler_if.slave    bus
);
    localparam int CW = (GRANT_MAX > 1) ? $clog2(GRANT_MAX) : 1;

    typedef enum logic [1:0] {ST_ACTIVE, ST_ARB, ST_GRANT} state_t;

    state_t          state_q, state_d;
    logic [9:0]      prev_y_q;
    logic [1:0]      grant_q, grant_d;
    logic [1:0]      served_q, served_d;
    logic            ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tick_q, tick_d;
    logic [7:0]      fcnt_q, fcnt_d;
    logic            ovr_q, ovr_d;
    logic            tmo_q, tmo_d;
    logic            ovr_set, tmo_set;

    logic            blank_start;
    logic            close_hit;
    logic            done_hit;
    logic            tmo_hit;
    logic            owner;
    logic [1:0]      eligible;

    assign blank_start = (bus.y == 10'(V_VISIBLE)) && (prev_y_q != 10'(V_VISIBLE));
    assign close_hit   = (bus.y == 10'(CLOSE_LINE));
    assign eligible    = bus.req & ~served_q;
    assign owner       = grant_q[1];
    // done is only honoured from the requester currently holding the grant
    assign done_hit    = |(bus.done & grant_q);
    assign tmo_hit     = (cnt_q == CW'(GRANT_MAX - 1));

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        served_d = served_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
        fcnt_d   = fcnt_q;
        ovr_set  = 1'b0;
        tmo_set  = 1'b0;

        case (state_q)
            ST_ACTIVE: begin
                grant_d = 2'b00;
                if (blank_start) begin
                    state_d  = ST_ARB;
                    tick_d   = 1'b1;
                    fcnt_d   = fcnt_q + 8'd1;
                    served_d = 2'b00;
                end
            end
            ST_ARB: begin
                // window close beats any pending request
                if (close_hit) begin
                    state_d = ST_ACTIVE;
                end else if (|eligible) begin
                    state_d = ST_GRANT;
                    cnt_d   = '0;
                    if (eligible == 2'b11) begin
                        grant_d = ptr_q ? 2'b10 : 2'b01;
                    end else begin
                        grant_d = eligible;
                    end
                end
            end
            ST_GRANT: begin
                cnt_d = cnt_q + 1'b1;
                // done > close > timeout; done never raises a flag
                if (done_hit) begin
                    grant_d  = 2'b00;
                    served_d = served_q | grant_q;
                    ptr_d    = ~owner;
                    state_d  = close_hit ? ST_ACTIVE : ST_ARB;
                end else if (close_hit) begin
                    grant_d = 2'b00;
                    ovr_set = 1'b1;
                    state_d = ST_ACTIVE;
                end else if (tmo_hit) begin
                    grant_d  = 2'b00;
                    tmo_set  = 1'b1;
                    served_d = served_q | grant_q;
                    ptr_d    = ~ptr_q;
                    state_d  = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
                grant_d = 2'b00;
            end
        endcase

        // a set event in the same cycle overrides clr_err
        ovr_d = ovr_set | (ovr_q & ~bus.clr_err);
        tmo_d = tmo_set | (tmo_q & ~bus.clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ACTIVE;
            prev_y_q <= 10'd0;
            grant_q  <= 2'b00;
            served_q <= 2'b00;
            ptr_q    <= 1'b0;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            fcnt_q   <= 8'd0;
            ovr_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_y_q <= bus.y;
            grant_q  <= grant_d;
            served_q <= served_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            fcnt_q   <= fcnt_d;
            ovr_q    <= ovr_d;
            tmo_q    <= tmo_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.frame_tick  = tick_q;
    assign bus.window_open = (state_q != ST_ACTIVE);
    assign bus.frame_count = fcnt_q;
    assign bus.overrun     = ovr_q;
    assign bus.timeout     = tmo_q;
endmodule

// File: doc/vblank_scheduler.md
VBLANK_SCHEDULER -- requirements
Module: vblank_scheduler

Interface
REQ-001 SHALL have parameter V_VISIBLE, default 480: first non-visible line number.
REQ-002 SHALL have parameter CLOSE_LINE, default 522: line at which the update window closes; must satisfy V_VISIBLE < CLOSE_LINE <= 524.
REQ-003 SHALL have parameter GRANT_MAX, default 4096: maximum clk cycles per grant.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port y, input, 10: current line from the VGA timing counter; changes at most once every 2 clk cycles.
REQ-007 SHALL have port req, input, 2: update request per requester (bit 0 paddle/ball logic, bit 1 brick logic).
REQ-008 SHALL have port done, input, 2: requester i finished its update; sampled only while grant[i]=1.
REQ-009 SHALL have port clr_err, input, 1: clears sticky error flags.
REQ-010 SHALL have port grant, output, 2: registered, one-hot or zero.
REQ-011 SHALL have port frame_tick, output, 1: one-cycle pulse at blanking start.
REQ-012 SHALL have port window_open, output, 1: high while grants may be issued.
REQ-013 SHALL have port frame_count, output, 8: blanking intervals seen, modulo 256.
REQ-014 SHALL have port overrun, output, 1: sticky; a grant was revoked at window close.
REQ-015 SHALL have port timeout, output, 1: sticky; a grant hit GRANT_MAX.

Function
REQ-016 SHALL register y into prev_y every cycle; blank_start = (y == V_VISIBLE) && (prev_y != V_VISIBLE).
REQ-017 SHALL implement states ACTIVE, ARB and GRANT.
REQ-018 In ACTIVE: window_open=0, grant=0; on blank_start the next cycle SHALL have state=ARB, frame_tick=1 for exactly that cycle, frame_count+1 (wraps 255->0), served[1:0] cleared.
REQ-019 In ARB: window_open=1; eligible = req & ~served; the next cycle grants the eligible requester with GRANT state; if both are eligible, the requester indicated by priority pointer ptr wins; if none, stay in ARB.
REQ-020 In ARB, y == CLOSE_LINE SHALL take precedence over arbitration: next state ACTIVE, no grant issued.
REQ-021 In GRANT: grant[i]=1, cycle counter increments from 0 each cycle.
REQ-022 done[i]=1 in GRANT SHALL drop grant next cycle, set served[i], set ptr to the other requester, return to ARB.
REQ-023 Counter reaching GRANT_MAX-1 without done SHALL drop grant next cycle, set timeout, set served[i], toggle ptr, return to ARB.
REQ-024 y == CLOSE_LINE in GRANT without done SHALL drop grant next cycle, set overrun, go to ACTIVE.
REQ-025 Simultaneous events in GRANT, precedence: done (no flag set) > close > timeout; done together with close SHALL go to ACTIVE with no overrun set.
REQ-026 Each requester SHALL receive at most one grant per blanking interval; req held after service is ignored until the next frame_tick.
REQ-027 Deasserting req while granted SHALL NOT release the grant; only done, timeout or close release it.
REQ-028 Latency: req to grant is 1 cycle minimum (from ARB); done to grant low is 1 cycle.
REQ-029 clr_err=1 SHALL clear overrun and timeout next cycle; a same-cycle set event wins over clear.

Reset
REQ-030 On rst: state=ACTIVE, grant=0, frame_tick=0, window_open=0, frame_count=0, overrun=0, timeout=0, served=0, ptr=0, counter=0, prev_y=0.
REQ-031 rst asserted mid-grant SHALL drop grant the next cycle with no flag set; after release, a blank_start with y already 480 SHALL be detected, because prev_y resets to 0.

Verification
REQ-032 Drive y 479->480, each line held 2 cycles -> frame_tick one 1-cycle pulse, frame_count 0->1, window_open=1 from the same cycle.
REQ-033 req=2'b11 at window open, ptr=0 -> grant=01; done[0] after 10 cycles -> grant=00 then grant=10; no third grant that frame.
REQ-034 GRANT_MAX=16, grant[1] with done never set -> grant drops after 16 cycles, timeout=1, requester 0 then granted if pending.
REQ-035 Grant active as y reaches 522 -> grant=00 next cycle, overrun=1, window_open=0; same with done on that cycle -> overrun stays 0.
REQ-036 clr_err pulse with flags set -> both clear; 256 frames -> frame_count wraps to 0; rst mid-grant -> all outputs at reset values.
